// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache with a 4-beat line refill.
// Read hits and writes complete combinationally; a read miss stalls the CPU until the line is back.
module cache_controller #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int INDEX_BITS = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              hit,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic {IDLE, REFILL} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] data_mem [LINES][LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;
  logic [1:0]        cnt;
  logic [ADDR_W-3:0] base_hi;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] idx, ref_idx;
  logic [TAG_W-1:0]      tag, ref_tag;
  logic                  wr_hit, miss_start, beat, beat_last;

  assign offset  = cpu_addr[1:0];
  assign idx     = cpu_addr[INDEX_BITS+1:2];
  assign tag     = cpu_addr[ADDR_W-1:INDEX_BITS+2];
  // base_hi is the latched word address without the offset bits
  assign ref_idx = base_hi[INDEX_BITS-1:0];
  assign ref_tag = base_hi[ADDR_W-3:INDEX_BITS];
  assign hit     = valid[idx] && (tag_mem[idx] == tag);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    wr_hit     = 1'b0;
    miss_start = 1'b0;
    beat       = 1'b0;
    beat_last  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_write) begin
          mem_write = 1'b1;
          cpu_ready = 1'b1;
          wr_hit    = hit;
        end else if (cpu_read) begin
          if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = data_mem[idx][offset];
          end else begin
            miss_start = 1'b1;
            state_nx   = REFILL;
          end
        end
      end
      REFILL: begin
        mem_read  = 1'b1;
        mem_addr  = {base_hi, 2'b00};
        beat      = mem_rvalid;
        beat_last = mem_rvalid && (cnt == 2'(LINE_WORDS - 1));
        if (beat_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset holds every strobe low and blocks all array updates this cycle.
    if (rst) begin
      state_nx   = IDLE;
      cpu_ready  = 1'b0;
      cpu_rdata  = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      wr_hit     = 1'b0;
      miss_start = 1'b0;
      beat       = 1'b0;
      beat_last  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      cnt   <= '0;
    end else begin
      if (miss_start) begin
        valid[idx] <= 1'b0;
        base_hi    <= cpu_addr[ADDR_W-1:2];
      end
      if (beat) cnt <= cnt + 2'd1;
      if (beat_last) begin
        valid[ref_idx] <= 1'b1;
        cnt            <= '0;
      end
    end
  end

  // Data and tag storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (wr_hit) data_mem[idx][offset] <= cpu_wdata;
    if (beat)   data_mem[ref_idx][cnt] <= mem_rdata;
    if (beat_last) tag_mem[ref_idx] <= ref_tag;
  end
endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller against a flat-memory plus line-presence model.
module tb_cache_controller;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cpu_read = 1'b0, cpu_write = 1'b0, mem_rvalid = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] cpu_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          cpu_ready, hit, mem_read, mem_write;

  int n_tests = 0, n_fail = 0;

  // Reference: memory is the source of truth (write-through keeps the cache coherent),
  // the cache model only tracks which line base each index currently holds.
  logic [DW-1:0] mem [logic [AW-1:0]];
  bit            mvalid [4];
  logic [AW-1:0] mbase [4];

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .hit(hit), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_write(mem_write),
    .mem_wdata(mem_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : a;
  endfunction

  function automatic logic [AW-1:0] lbase(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  function automatic bit mhit(input logic [AW-1:0] a);
    return mvalid[a[3:2]] && (mbase[a[3:2]] == lbase(a));
  endfunction

  task automatic do_idle(input bit stray);
    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b0;
    mem_rvalid = stray; mem_rdata = $urandom;
    #1;
    chk("idle_ready", cpu_ready, 0);
    chk("idle_mem_read", mem_read, 0);
    chk("idle_mem_write", mem_write, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit also_rd);
    @(negedge clk);
    cpu_write = 1'b1; cpu_read = also_rd; cpu_addr = a; cpu_wdata = d; mem_rvalid = 1'b0;
    #1;
    chk("wr_mem_write", mem_write, 1);
    chk("wr_mem_addr", mem_addr, a);
    chk("wr_mem_wdata", mem_wdata, d);
    chk("wr_ready", cpu_ready, 1);
    chk("wr_hit", hit, mhit(a));
    chk("wr_mem_read", mem_read, 0);
    mem[a] = d;
  endtask

  // rst_at >= 0 asserts reset once that many beats have been delivered.
  task automatic do_read(input logic [AW-1:0] a, input bit use_pat, input logic [15:0] pat,
                         input int rst_at);
    bit h, rv;
    int beats, cyc;
    logic [AW-1:0] b;
    b = lbase(a);
    h = mhit(a);
    @(negedge clk);
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = a; mem_rvalid = 1'b0;
    #1;
    chk("rd_hit", hit, h);
    chk("rd_ready", cpu_ready, h);
    chk("rd_mem_write", mem_write, 0);
    if (h) begin
      chk("rd_data", cpu_rdata, mrd(a));
      chk("rd_no_fetch", mem_read, 0);
      return;
    end
    mvalid[a[3:2]] = 1'b0;
    beats = 0;
    cyc = 0;
    while (beats < 4) begin
      @(negedge clk);
      if (beats == rst_at) begin
        rst = 1'b1; mem_rvalid = 1'b0;
        #1;
        chk("rst_ready", cpu_ready, 0);
        @(negedge clk);
        rst = 1'b0; cpu_read = 1'b0;
        foreach (mvalid[i]) mvalid[i] = 1'b0;
        repeat (2) begin
          mem_rvalid = 1'b1; mem_rdata = $urandom;
          #1;
          chk("post_rst_mem_read", mem_read, 0);
          chk("post_rst_hit", hit, 0);
          chk("post_rst_ready", cpu_ready, 0);
          @(negedge clk);
        end
        mem_rvalid = 1'b0;
        return;
      end
      rv = use_pat ? ((cyc < 16) ? pat[cyc] : 1'b1) : ($urandom_range(0, 2) != 0);
      if (cyc >= 20) rv = 1'b1;
      mem_rvalid = rv;
      mem_rdata = rv ? mrd(b + AW'(beats)) : $urandom;
      #1;
      chk("refill_mem_read", mem_read, 1);
      chk("refill_addr", mem_addr, b);
      chk("refill_ready", cpu_ready, 0);
      if (rv) beats++;
      cyc++;
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    mvalid[a[3:2]] = 1'b1;
    mbase[a[3:2]] = b;
    chk("fill_hit", hit, 1);
    chk("fill_ready", cpu_ready, 1);
    chk("fill_data", cpu_rdata, mrd(a));
    chk("fill_mem_read", mem_read, 0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return {$urandom_range(0, 3) == 0 ? 26'h3FF_FFFF : 26'($urandom), 6'($urandom)};
    return AW'($urandom_range(0, 63));
  endfunction

  initial begin
    logic [AW-1:0] a;
    int op;
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_ready", cpu_ready, 0);
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_rdata", cpu_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    cpu_addr = 32'h0;
    #1;
    chk("cold_hit", hit, 0);

    // Directed scenarios
    do_read(32'h5, 0, 16'h0, -1);
    do_read(32'h4, 0, 16'h0, -1);
    do_read(32'h6, 0, 16'h0, -1);
    do_read(32'h7, 0, 16'h0, -1);
    do_write(32'h6, 32'hDEADBEEF, 0);
    do_read(32'h6, 0, 16'h0, -1);
    do_write(32'h40, 32'h1234_5678, 0);
    do_read(32'h5, 0, 16'h0, -1);
    do_read(32'h15, 0, 16'h0, -1);
    do_read(32'h5, 0, 16'h0, -1);
    do_read(32'h25, 1, 16'b1011001, -1);
    do_read(32'h26, 0, 16'h0, -1);
    do_read(32'h9, 0, 16'h0, 2);
    do_read(32'h9, 0, 16'hFFFF, -1);
    do_read(32'hFFFF_FFFE, 0, 16'h0, -1);
    do_read(32'hFFFF_FFFC, 0, 16'h0, -1);

    // Randomized mix
    repeat (400) begin
      op = $urandom_range(0, 9);
      a = rand_addr();
      case (op)
        0, 1, 2, 3: do_read(a, 0, 16'h0, -1);
        4, 5:       do_write(a, $urandom, 0);
        6:          do_write(a, $urandom, 1);
        7:          do_read(a, 0, 16'h0, $urandom_range(0, 3));
        8:          do_idle(1);
        default:    begin do_read(a, 0, 16'h0, -1); do_read(lbase(a) + AW'($urandom_range(0, 3)), 0, 16'h0, -1); end
      endcase
    end
    do_idle(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
